// File: rtl/cpu6_shifter_pkg.sv
// rtl/cpu6_shifter_pkg.sv - shared widths and FSM encoding for the cpu6 iterative shifter
// Purpose: single source for operand/amount widths, per-cycle step size and state encoding.
// Ports: none (package).
package cpu6_shifter_pkg;

    localparam int CPU6_XLEN            = 32;
    localparam int CPU6_SHAMT_SIZE      = 5;
    localparam int CPU6_SHFT_STEP       = 4;
    localparam int CPU6_SHFT_STATE_SIZE = 2;

    typedef enum logic [CPU6_SHFT_STATE_SIZE-1:0] {
        CPU6_SHFT_IDLE  = 2'd0,
        CPU6_SHFT_SHIFT = 2'd1,
        CPU6_SHFT_DONE  = 2'd2
    } cpu6_shft_state_e;

endpackage

// File: rtl/cpu6_shifter_if.sv
// rtl/cpu6_shifter_if.sv - EX-stage request/response bundle between decoder and shifter
// Purpose: groups the shift request, flush and stall/valid/result signals.
// Modports: master = decoder/pipeline side (drives request and flush),
//           slave  = shifter side (drives stall, valid and result).
interface cpu6_shifter_if
    import cpu6_shifter_pkg::*;
#(
    parameter int XLEN    = CPU6_XLEN,
    parameter int SHAMT_W = CPU6_SHAMT_SIZE
);

    logic               shft_en;
    logic               shft_lr;
    logic               shft_arith;
    logic [XLEN-1:0]    shft_a;
    logic [SHAMT_W-1:0] shft_amt;
    logic               flush;
    logic               shft_stall;
    logic               shft_vld;
    logic [XLEN-1:0]    shft_res;

    modport master (
        output shft_en, shft_lr, shft_arith, shft_a, shft_amt, flush,
        input  shft_stall, shft_vld, shft_res
    );

    modport slave (
        input  shft_en, shft_lr, shft_arith, shft_a, shft_amt, flush,
        output shft_stall, shft_vld, shft_res
    );

endinterface

// File: rtl/cpu6_shft_step.sv
// rtl/cpu6_shft_step.sv - one combinational shift step of 0..STEP bit positions
// Purpose: shifts data_i by k_i in the given direction, filling vacated bits.
// Ports: data_i (operand), k_i (shift distance), dir_i (1 = right, 0 = left),
//        fill_i (bit shifted in on right shifts), data_o (shifted value).
module cpu6_shft_step
    import cpu6_shifter_pkg::*;
#(
    parameter int XLEN = CPU6_XLEN,
    parameter int KW   = CPU6_SHAMT_SIZE + 1
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [KW-1:0]   k_i,
    input  logic            dir_i,
    input  logic            fill_i,
    output logic [XLEN-1:0] data_o
);

    // Ones in the top k_i positions: the bits vacated by a right shift.
    logic [XLEN-1:0] hi_mask;

    always_comb begin
        hi_mask = ~({XLEN{1'b1}} >> k_i);
        if (dir_i) begin
            data_o = (data_i >> k_i) | (hi_mask & {XLEN{fill_i}});
        end else begin
            data_o = data_i << k_i;
        end
    end

endmodule

// File: rtl/cpu6_shifter.sv
// rtl/cpu6_shifter.sv - multi-cycle iterative shifter for the cpu6 execute stage
// Purpose: accepts a shift from the ALU decoder, shifts up to STEP bits per cycle,
//          stalls the pipeline until done and pulses shft_vld with the result.
// Ports: clk, reset (synchronous, active-high), bus (slave side of cpu6_shifter_if:
//        shft_en/shft_lr/shft_arith/shft_a/shft_amt/flush in, shft_stall/shft_vld/shft_res out).
module cpu6_shifter
    import cpu6_shifter_pkg::*;
#(
    parameter int XLEN    = CPU6_XLEN,
    parameter int SHAMT_W = CPU6_SHAMT_SIZE,
    parameter int STEP    = CPU6_SHFT_STEP
) (
    input  logic           clk,
    input  logic           reset,
    cpu6_shifter_if.slave  bus
);

    // One extra bit so that STEP == XLEN is representable as a step distance.
    localparam int            KW     = SHAMT_W + 1;
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    cpu6_shft_state_e state_q;
    logic [KW-1:0]    cnt_q;
    logic [XLEN-1:0]  data_q;
    logic [XLEN-1:0]  res_q;
    logic             dir_q;
    logic             fill_q;
    logic             vld_q;

    logic [KW-1:0]    k_d;
    logic [XLEN-1:0]  data_d;

    assign k_d = (cnt_q > STEP_K) ? STEP_K : cnt_q;

    cpu6_shft_step #(
        .XLEN (XLEN),
        .KW   (KW)
    ) u_step (
        .data_i (data_q),
        .k_i    (k_d),
        .dir_i  (dir_q),
        .fill_i (fill_q),
        .data_o (data_d)
    );

    // vld_q is set on the edge entering DONE, so it is high exactly while in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CPU6_SHFT_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= CPU6_SHFT_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                CPU6_SHFT_IDLE: begin
                    vld_q <= 1'b0;
                    if (bus.shft_en) begin
                        data_q <= bus.shft_a;
                        cnt_q  <= {1'b0, bus.shft_amt};
                        dir_q  <= bus.shft_lr;
                        fill_q <= bus.shft_arith & bus.shft_lr & bus.shft_a[XLEN-1];
                        if (bus.shft_amt == '0) begin
                            state_q <= CPU6_SHFT_DONE;
                            vld_q   <= 1'b1;
                            res_q   <= bus.shft_a;
                        end else begin
                            state_q <= CPU6_SHFT_SHIFT;
                        end
                    end
                end
                CPU6_SHFT_SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - k_d;
                    if (cnt_q == k_d) begin
                        state_q <= CPU6_SHFT_DONE;
                        vld_q   <= 1'b1;
                        res_q   <= data_d;
                    end
                end
                CPU6_SHFT_DONE: begin
                    // shft_en here is still the finished instruction; never re-accept it.
                    state_q <= CPU6_SHFT_IDLE;
                    vld_q   <= 1'b0;
                end
                default: begin
                    state_q <= CPU6_SHFT_IDLE;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.shft_stall = bus.shft_en & ~vld_q & ~bus.flush;
    assign bus.shft_vld   = vld_q;
    assign bus.shft_res   = res_q;

    // The pipeline must hold the instruction while stalled; the op still completes if not.
    a_en_held_in_shift: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == CPU6_SHFT_SHIFT && !bus.flush) |-> bus.shft_en
    );

endmodule

// File: tb/tb_cpu6_shifter.sv
// tb/tb_cpu6_shifter.sv - self-checking bench for cpu6_shifter
module tb_cpu6_shifter;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 4;

    logic clk;
    logic reset;

    cpu6_shifter_if #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) bus ();

    cpu6_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  amt;
        logic        lr;
        logic        arith;
        bit          scramble;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[10];

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [31:0] a, input int amt,
                                              input logic lr, input logic arith);
        if (!lr) return a << amt;
        if (arith) return $unsigned($signed(a) >>> amt);
        return a >> amt;
    endfunction

    function automatic int model_lat(input int amt);
        if (amt == 0) return 1;
        return 1 + (amt + STEP - 1) / STEP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.shft_a     = $urandom;
        bus.shft_amt   = 5'($urandom);
        bus.shft_lr    = 1'($urandom);
        bus.shft_arith = 1'($urandom);
    endtask

    // Starts in the accept cycle (already ticked), ends in the DONE cycle.
    task automatic run_op(input logic [31:0] a, input logic [4:0] amt, input logic lr,
                          input logic arith, input bit scramble, input logic [31:0] exp);
        int lat;
        lat = model_lat(int'(amt));
        bus.flush      = 1'b0;
        bus.shft_en    = 1'b1;
        bus.shft_a     = a;
        bus.shft_amt   = amt;
        bus.shft_lr    = lr;
        bus.shft_arith = arith;
        #1;
        check_bit("accept_stall", bus.shft_stall, 1'b1);
        check_bit("accept_vld", bus.shft_vld, 1'b0);
        for (int c = 1; c < lat; c++) begin
            tick();
            if (scramble) scramble_inputs();
            #1;
            check_bit("busy_stall", bus.shft_stall, 1'b1);
            check_bit("busy_vld", bus.shft_vld, 1'b0);
        end
        tick();
        if (scramble) scramble_inputs();
        #1;
        check_bit("done_vld", bus.shft_vld, 1'b1);
        check_word("done_res", bus.shft_res, exp);
        check_bit("done_stall", bus.shft_stall, 1'b0);
        last_res = exp;
    endtask

    task automatic idle();
        tick();
        bus.shft_en = 1'b0;
        bus.flush   = 1'b0;
        scramble_inputs();
        #1;
        check_bit("idle_vld", bus.shft_vld, 1'b0);
        check_bit("idle_stall", bus.shft_stall, 1'b0);
        check_word("idle_res_hold", bus.shft_res, last_res);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0000};
        vecs[1] = '{32'h8000_0000, 5'd4,  1'b1, 1'b1, 1'b0, 32'hF800_0000};
        vecs[2] = '{32'h8000_0000, 5'd4,  1'b1, 1'b0, 1'b0, 32'h0800_0000};
        vecs[3] = '{32'h8000_0000, 5'd13, 1'b1, 1'b0, 1'b1, 32'h0004_0000};
        vecs[4] = '{32'h1234_5678, 5'd0,  1'b1, 1'b1, 1'b0, 32'h1234_5678};
        vecs[5] = '{32'h0000_000F, 5'd4,  1'b0, 1'b0, 1'b1, 32'h0000_00F0};
        vecs[6] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{32'h7FFF_FFF0, 5'd4,  1'b1, 1'b1, 1'b0, 32'h07FF_FFFF};
        vecs[8] = '{32'h8000_0001, 5'd1,  1'b0, 1'b1, 1'b0, 32'h0000_0002};
        vecs[9] = '{32'hFFFF_FFFF, 5'd5,  1'b1, 1'b0, 1'b1, 32'h07FF_FFFF};

        reset          = 1'b1;
        bus.shft_en    = 1'b0;
        bus.flush      = 1'b0;
        bus.shft_lr    = 1'b0;
        bus.shft_arith = 1'b0;
        bus.shft_a     = 32'h0;
        bus.shft_amt   = 5'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_bit("reset_vld", bus.shft_vld, 1'b0);
        check_bit("reset_stall", bus.shft_stall, 1'b0);
        check_word("reset_res", bus.shft_res, 32'h0);

        // Directed table.
        foreach (vecs[i]) begin
            tick();
            run_op(vecs[i].a, vecs[i].amt, vecs[i].lr, vecs[i].arith,
                   vecs[i].scramble, vecs[i].exp_res);
            idle();
            idle();
        end

        // Back-to-back: amt=0 then SLLI accepted the cycle after DONE.
        tick();
        run_op(32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        tick();
        run_op(32'h0000_000F, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0000_00F0);
        idle();

        // Flush mid-shift (amt=20) at T+2, then new request at T+3.
        tick();
        bus.shft_en = 1'b1; bus.shft_a = 32'hAAAA_5555; bus.shft_amt = 5'd20;
        bus.shft_lr = 1'b0; bus.shft_arith = 1'b0;
        #1;
        check_bit("flush_accept_stall", bus.shft_stall, 1'b1);
        tick(); #1;
        check_bit("flush_t1_vld", bus.shft_vld, 1'b0);
        tick(); bus.flush = 1'b1; #1;
        check_bit("flush_stall", bus.shft_stall, 1'b0);
        check_bit("flush_vld", bus.shft_vld, 1'b0);
        tick();
        run_op(32'h0000_00FF, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0000_FF00);
        idle();

        // Flush landing in DONE: the registered pulse still appears.
        tick();
        bus.shft_en = 1'b1; bus.shft_a = 32'h0000_0012; bus.shft_amt = 5'd4;
        bus.shft_lr = 1'b0; bus.shft_arith = 1'b0;
        tick();
        tick(); bus.flush = 1'b1; #1;
        check_bit("flush_done_vld", bus.shft_vld, 1'b1);
        check_word("flush_done_res", bus.shft_res, 32'h0000_0120);
        last_res = 32'h0000_0120;
        idle();
        idle();

        // Flush together with shft_en in IDLE: nothing accepted.
        tick();
        bus.shft_en = 1'b1; bus.flush = 1'b1; bus.shft_a = 32'hDEAD_BEEF; bus.shft_amt = 5'd0;
        #1;
        check_bit("flush_idle_stall", bus.shft_stall, 1'b0);
        idle();
        idle();

        // Reset mid-shift clears result and returns to IDLE.
        tick();
        bus.shft_en = 1'b1; bus.shft_a = 32'h0000_0001; bus.shft_amt = 5'd20;
        bus.shft_lr = 1'b0; bus.shft_arith = 1'b0;
        tick();
        tick();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; bus.shft_en = 1'b0; #1;
        check_bit("rst_mid_vld", bus.shft_vld, 1'b0);
        check_bit("rst_mid_stall", bus.shft_stall, 1'b0);
        check_word("rst_mid_res", bus.shft_res, 32'h0);
        last_res = 32'h0;
        tick();
        run_op(32'hF000_0000, 5'd7, 1'b1, 1'b1, 1'b0, 32'hFFE0_0000);
        idle();

        // Randomized ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [4:0]  amt;
            logic        lr;
            logic        arith;
            a     = $urandom;
            case ($urandom_range(0, 5))
                0:       amt = 5'd0;
                1:       amt = 5'd31;
                default: amt = 5'($urandom);
            endcase
            lr    = 1'($urandom);
            arith = 1'($urandom);
            tick();
            run_op(a, amt, lr, arith, bit'($urandom_range(0, 1)),
                   model_res(a, int'(amt), lr, arith));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
